if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Parametrised instruction-fetch stage for the MIPS core: holds the fetch PC, issues in-order requests on the instruction SRAM-like bus with multiple requests outstanding, buffers returned instructions in a PC-tagged queue, and hands them to decode over a valid/ready handshake. Exception and branch/jump redirects flush the queue and discard stale in-flight responses. Sits between the instruction bus and the ID stage.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch address after reset
- DEPTH, 4, queue entries and maximum in-flight requests; power of 2, ≥ 2
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- redirect_i  in  1  branch/jump redirect from EX
- redirect_pc_i  in  32  redirect target
- exc_i  in  1  exception/eret redirect from MEM, priority over redirect_i
- exc_pc_i  in  32  exception target
- inst_req_o  out  1  bus request valid
- inst_addr_o  out  32  bus request address
- inst_addr_ok_i  in  1  request accepted this cycle
- inst_data_ok_i  in  1  read data returned this cycle (in request order)
- inst_rdata_i  in  32  read data
- valid_o  out  1  queue head valid to decode
- ready_i  in  1  decode accepts head
- pc_o  out  32  PC of head entry
- inst_o  out  32  instruction of head entry
- adel_o  out  1  head entry carries address-error flag

## Operation
- State: fetch_pc, queue (pc, inst, adel) with head/tail pointers and count, alloc (reserved slots = count + requests accepted but not returned), discard counter.
- inst_addr_o = fetch_pc; inst_req_o = 1 when alloc + discard < DEPTH and not halted (see Configuration), no flush this cycle.
- Accept (req & addr_ok): fetch_pc += 4 (wraps mod 2^32), alloc++ and pending PC recorded in reserved slot order.
- Return (data_ok): if discard > 0, discard--, data dropped; else inst written to oldest pending reserved slot, which becomes visible.
- Pop (valid_o & ready_i): head advances, count--, alloc--.
- Flush (exc_i | redirect_i): target = exc_i ? exc_pc_i : redirect_pc_i; fetch_pc ← target; queue cleared (valid_o 0 next cycle); discard ← discard + pending in flight, counting an accept and subtracting a non-discarded return in the same cycle. Pop in flush cycle ignored.
- Simultaneous pop and return: both apply; count unchanged.
- Bus protocol: inst_addr_o held stable while inst_req_o is high and addr_ok low, except on flush.

## Timing
- Reset: fetch_pc = RESET_PC, queue empty, discard 0; inst_req_o 0, inst_addr_o RESET_PC, valid_o 0, pc_o 0, inst_o 0, adel_o 0.
- First request: inst_req_o 1 in first cycle after rst_i deasserts.
- Return-to-valid latency: entry filled on data_ok edge, valid_o high next cycle (registered queue; no bypass).
- Flush: target request issued the cycle after flush is sampled.
- Full throughput: one instruction per cycle when bus returns one per cycle and ready_i held high.
- Reset mid-operation: all state cleared; responses to pre-reset requests are the bus's responsibility (bus resets too).

## Configuration
- IF_ADEL_CHECK_EN defined: when fetch_pc[1:0] ≠ 0, no bus request; one entry {pc=fetch_pc, inst=0, adel=1} pushed when a slot is free, then fetch halts (inst_req_o 0) until next flush or reset.
- Undefined: no check; inst_addr_o = {fetch_pc[31:2], 2'b00}, adel_o tied 0.

## Test plan
- Reset release, bus addr_ok/data_ok every cycle, ready_i 1 -> pc_o 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive valid cycles; first valid_o 2 cycles after first addr_ok.
- ready_i 0, bus always ready, DEPTH 4 -> exactly 4 accepts, then inst_req_o 0; raising ready_i releases one request per pop.
- 3 requests in flight, redirect_i with 0x8000_0100 -> next inst_addr_o 0x8000_0100, 3 returns dropped, first valid pc_o 0x8000_0100 with matching inst.
- exc_i (0xBFC00380) and redirect_i (0x8000_0000) same cycle -> fetch resumes at 0xBFC00380.
- Flush coinciding with accept and return -> discard count correct; no stale inst ever reaches valid_o (scoreboard on pc/inst pairs).
- With IF_ADEL_CHECK_EN, redirect to 0x8000_0002 -> no bus request, one entry adel_o 1, pc_o 0x8000_0002, inst_o 0; fetch halted until next redirect.

Source files
------------

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: issues in-order bus requests, keeps a PC-tagged return queue
// and discards stale responses after redirects. Define IF_ADEL_CHECK_EN for misaligned-PC AdEL entries.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_i,
  input  logic [31:0] exc_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        adel_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] alloc_q, alloc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      slot_pc_q   [DEPTH];
  logic [31:0]      slot_pc_d   [DEPTH];
  logic [31:0]      slot_inst_q [DEPTH];
  logic [31:0]      slot_inst_d [DEPTH];

  logic             flush, fetch_block, adel_push, req, accept;
  logic             has_pending, ret_fill, ret_drop, pop;
  logic [31:0]      target_pc;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] pending;
  logic [PTR_W-1:0] res_idx, fill_idx;

  // Slots head..head+count-1 hold returned data; head+count..head+alloc-1 await returns.
  assign flush       = exc_i | redirect_i;
  assign target_pc   = exc_i ? exc_pc_i : redirect_pc_i;
  assign occupancy   = {1'b0, alloc_q} + {1'b0, discard_q};
  assign pending     = alloc_q - count_q;
  assign has_pending = alloc_q != count_q;
  assign res_idx     = head_q + alloc_q[PTR_W-1:0];
  assign fill_idx    = head_q + count_q[PTR_W-1:0];

  assign req      = !rst_i && !flush && !fetch_block && (occupancy < DEPTH_OCC);
  assign accept   = req & inst_addr_ok_i;
  assign ret_drop = inst_data_ok_i && (discard_q != '0);
  assign ret_fill = inst_data_ok_i && (discard_q == '0) && has_pending;
  assign pop      = valid_o & ready_i;

  assign inst_req_o = req;
  assign valid_o    = count_q != '0;
  assign pc_o       = slot_pc_q[head_q];
  assign inst_o     = slot_inst_q[head_q];

`ifdef IF_ADEL_CHECK_EN
  logic halted_q, halted_d;
  logic slot_adel_q [DEPTH];
  logic slot_adel_d [DEPTH];
  logic misaligned;

  // Misaligned PCs never reach the bus; a single AdEL entry is queued once older work is back.
  assign misaligned  = fetch_pc_q[1:0] != 2'b00;
  assign fetch_block = halted_q | misaligned;
  assign adel_push   = !flush && !halted_q && misaligned && !has_pending &&
                       ({1'b0, alloc_q} < DEPTH_OCC);
  assign inst_addr_o = fetch_pc_q;
  assign adel_o      = slot_adel_q[head_q];
`else
  assign fetch_block = 1'b0;
  assign adel_push   = 1'b0;
  assign inst_addr_o = {fetch_pc_q[31:2], 2'b00};
  assign adel_o      = 1'b0;
`endif

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    count_d     = count_q;
    alloc_d     = alloc_q;
    discard_d   = discard_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;
`ifdef IF_ADEL_CHECK_EN
    halted_d    = halted_q;
    slot_adel_d = slot_adel_q;
`endif
    if (flush) begin
      // Everything still owed by the bus becomes a response to throw away.
      fetch_pc_d = target_pc;
      count_d    = '0;
      alloc_d    = '0;
      discard_d  = discard_q + pending - CNT_W'(ret_drop) - CNT_W'(ret_fill);
`ifdef IF_ADEL_CHECK_EN
      halted_d   = 1'b0;
`endif
    end else begin
      if (accept) begin
        slot_pc_d[res_idx] = fetch_pc_q;
        fetch_pc_d         = fetch_pc_q + 32'd4;
`ifdef IF_ADEL_CHECK_EN
        slot_adel_d[res_idx] = 1'b0;
`endif
      end
      if (adel_push) begin
        slot_pc_d[res_idx]   = fetch_pc_q;
        slot_inst_d[res_idx] = '0;
`ifdef IF_ADEL_CHECK_EN
        slot_adel_d[res_idx] = 1'b1;
        halted_d             = 1'b1;
`endif
      end
      if (ret_fill) begin
        slot_inst_d[fill_idx] = inst_rdata_i;
      end
      if (ret_drop) begin
        discard_d = discard_q - CNT_W'(1);
      end
      count_d = count_q + CNT_W'(ret_fill) + CNT_W'(adel_push) - CNT_W'(pop);
      alloc_d = alloc_q + CNT_W'(accept) + CNT_W'(adel_push) - CNT_W'(pop);
      head_d  = head_q + PTR_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      count_q    <= '0;
      alloc_q    <= '0;
      discard_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]   <= '0;
        slot_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      head_q      <= head_d;
      count_q     <= count_d;
      alloc_q     <= alloc_d;
      discard_q   <= discard_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
    end
  end

`ifdef IF_ADEL_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_adel_q[i] <= 1'b0;
      end
    end else begin
      halted_q    <= halted_d;
      slot_adel_q <= slot_adel_d;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a queue-based reference of the fetch stage and a simple
// in-order bus responder, plus directed scenarios for throughput, back-pressure and redirects.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        exc_i;
  logic [31:0] exc_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        adel_o;

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .exc_i(exc_i), .exc_pc_i(exc_pc_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i), .inst_rdata_i(inst_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .adel_o(adel_o)
  );

  typedef struct {logic [31:0] pc; bit stale;} flight_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst; bit adel;} entry_t;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_pc;
  bit          m_halted;
  flight_t     m_flight[$];
  entry_t      m_fifo[$];
  logic [31:0] bus_q[$];

  int          cyc, first_accept_cyc, first_valid_cyc, dut_accepts, req_cycles;
  logic [31:0] last_addr;
  logic [31:0] seen_pc[$];
  logic [31:0] seen_inst[$];
  logic        seen_adel[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit anyLive();
    foreach (m_flight[i]) if (!m_flight[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit modelReq(input bit flush);
    if (flush || m_halted) return 1'b0;
`ifdef IF_ADEL_CHECK_EN
    if (m_pc[1:0] != 2'b00) return 1'b0;
`endif
    return (m_fifo.size() + m_flight.size()) < DEPTH;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1; redirect_i = 1'b0; exc_i = 1'b0; redirect_pc_i = '0; exc_pc_i = '0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0; ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("rst_req", inst_req_o, 1'b0);
    checkOutput("rst_addr", inst_addr_o, RESET_PC);
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_inst", inst_o, 32'h0);
    checkOutput("rst_adel", adel_o, 1'b0);
    m_pc = RESET_PC; m_halted = 1'b0;
    m_flight.delete(); m_fifo.delete(); bus_q.delete();
    seen_pc.delete(); seen_inst.delete(); seen_adel.delete();
    cyc = 0; first_accept_cyc = -1; first_valid_cyc = -1; dut_accepts = 0; req_cycles = 0;
  endtask

  // One clock of stimulus: drive, compare against the reference, then advance the reference.
  task automatic applyStimulus(input bit ready, input bit aok, input bit dok,
                               input bit redir, input logic [31:0] rpc,
                               input bit exc, input logic [31:0] epc);
    bit          flush, req, adel_go;
    flight_t     f;
    entry_t      e;
    @(negedge clk_i);
    rst_i = 1'b0;
    ready_i = ready; inst_addr_ok_i = aok;
    inst_data_ok_i = dok && (bus_q.size() > 0);
    inst_rdata_i = inst_data_ok_i ? memWord(bus_q[0]) : 32'hDEAD_BEEF;
    redirect_i = redir; redirect_pc_i = rpc; exc_i = exc; exc_pc_i = epc;
    #1;
    flush = redir | exc;
    req = modelReq(flush);
    checkOutput("inst_req_o", inst_req_o, req);
    if (req) checkOutput("inst_addr_o", inst_addr_o, {m_pc[31:2], 2'b00});
    checkOutput("valid_o", valid_o, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      checkOutput("pc_o", pc_o, m_fifo[0].pc);
      checkOutput("inst_o", inst_o, m_fifo[0].inst);
      checkOutput("adel_o", adel_o, m_fifo[0].adel);
    end

    last_addr = inst_addr_o;
    if (inst_req_o) req_cycles++;
    if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (valid_o && ready_i && !flush) begin
      seen_pc.push_back(pc_o); seen_inst.push_back(inst_o); seen_adel.push_back(adel_o);
    end
    if (inst_data_ok_i) void'(bus_q.pop_front());
    if (inst_req_o && inst_addr_ok_i) begin
      bus_q.push_back(inst_addr_o);
      dut_accepts++;
      if (first_accept_cyc < 0) first_accept_cyc = cyc;
    end

    adel_go = !flush && !m_halted && (m_pc[1:0] != 2'b00) && (m_fifo.size() < DEPTH) && !anyLive();
    if (flush) begin
      if (inst_data_ok_i && m_flight.size() > 0) void'(m_flight.pop_front());
      foreach (m_flight[i]) m_flight[i].stale = 1'b1;
      m_fifo.delete();
      m_pc = exc ? epc : rpc;
      m_halted = 1'b0;
    end else begin
      if (m_fifo.size() > 0 && ready) void'(m_fifo.pop_front());
      if (inst_data_ok_i && m_flight.size() > 0) begin
        f = m_flight.pop_front();
        if (!f.stale) begin
          e.pc = f.pc; e.inst = memWord(f.pc); e.adel = 1'b0;
          m_fifo.push_back(e);
        end
      end
      if (req && aok) begin
        f.pc = m_pc; f.stale = 1'b0;
        m_flight.push_back(f);
        m_pc = m_pc + 32'd4;
      end
`ifdef IF_ADEL_CHECK_EN
      if (adel_go) begin
        e.pc = m_pc; e.inst = 32'h0; e.adel = 1'b1;
        m_fifo.push_back(e);
        m_halted = 1'b1;
      end
`endif
    end
    cyc++;
  endtask

  initial begin
    doReset();

    // Streaming with the bus and decode always ready.
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("stream_n", seen_pc.size() >= 3, 1'b1);
    if (seen_pc.size() >= 3) begin
      checkOutput("stream_pc0", seen_pc[0], 32'hBFC0_0000);
      checkOutput("stream_pc1", seen_pc[1], 32'hBFC0_0004);
      checkOutput("stream_pc2", seen_pc[2], 32'hBFC0_0008);
      checkOutput("stream_inst1", seen_inst[1], memWord(32'hBFC0_0004));
    end
    checkOutput("first_req_cycle", first_accept_cyc, 0);
    checkOutput("valid_latency", first_valid_cyc - first_accept_cyc, 2);

    // Decode stalled: the queue fills and requests stop at DEPTH.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, '0, 0, '0);
    checkOutput("full_accepts", dut_accepts, DEPTH);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("release_accepts", dut_accepts > DEPTH, 1'b1);

    // Redirect with three requests outstanding.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, '0, 0, '0);
    seen_pc.delete(); seen_inst.delete(); seen_adel.delete();
    applyStimulus(1, 1, 0, 1, 32'h8000_0100, 0, '0);
    applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("redir_addr", last_addr, 32'h8000_0100);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("redir_seen", seen_pc.size() >= 1, 1'b1);
    if (seen_pc.size() >= 1) begin
      checkOutput("redir_pc0", seen_pc[0], 32'h8000_0100);
      checkOutput("redir_inst0", seen_inst[0], memWord(32'h8000_0100));
    end

    // Exception wins over a simultaneous branch redirect.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    applyStimulus(1, 1, 1, 1, 32'h8000_0000, 1, 32'hBFC0_0380);
    applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("exc_addr", last_addr, 32'hBFC0_0380);

`ifdef IF_ADEL_CHECK_EN
    // Misaligned redirect target yields one AdEL entry and halts fetch.
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    seen_pc.delete(); seen_inst.delete(); seen_adel.delete();
    applyStimulus(1, 1, 1, 1, 32'h8000_0002, 0, '0);
    req_cycles = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("adel_halt_req", req_cycles, 0);
    checkOutput("adel_seen", seen_pc.size(), 1);
    if (seen_pc.size() >= 1) begin
      checkOutput("adel_pc", seen_pc[0], 32'h8000_0002);
      checkOutput("adel_inst", seen_inst[0], 32'h0);
      checkOutput("adel_flag", seen_adel[0], 1'b1);
    end
    applyStimulus(1, 1, 1, 1, 32'h8000_0200, 0, '0);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0);
    checkOutput("adel_resume", req_cycles != 0, 1'b1);
`endif

    // Randomised traffic with flushes landing on returns and occasional resets.
    doReset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 15) == 0, $urandom() & 32'hFFFF_FFFC,
                      $urandom_range(0, 31) == 0, $urandom() & 32'hFFFF_FFFC);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
